// File: rtl/alu_issue_arbiter_pkg.sv
// Shared types for the ALU issue arbiter: decoded op encoding and the per-slot request bundle.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package alu_issue_arbiter_pkg;

  localparam int unsigned ALU_TAG_WIDTH  = 6;
  localparam int unsigned ALU_DATA_WIDTH = `DATA_WIDTH;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLL = 3'd5,
    ALU_SRL = 3'd6,
    ALU_SLT = 3'd7
  } decoded_alu_op_t;

  typedef struct packed {
    decoded_alu_op_t             op;
    logic [ALU_DATA_WIDTH-1:0]   src1;
    logic [ALU_DATA_WIDTH-1:0]   src2;
    logic [ALU_TAG_WIDTH-1:0]    tag;
  } alu_req_t;

endpackage

// File: rtl/alu_issue_arbiter_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or above the pointer, wrapping modulo N.
module rr_arbiter #(
  parameter  int unsigned N     = 4,
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [N-1:0]     i_req,
  input  logic             i_en,
  input  logic             i_advance,
  output logic [N-1:0]     o_gnt,
  output logic [IDX_W-1:0] o_gnt_idx
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             found;
  int unsigned      idx;

  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int unsigned off = 0; off < N; off++) begin
      idx = int'(ptr_q) + off;
      if (idx >= N) idx = idx - N;
      if (!found && i_en && i_req[idx]) begin
        found          = 1'b1;
        o_gnt[idx]     = 1'b1;
        o_gnt_idx      = IDX_W'(idx);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (i_advance && found) begin
      ptr_d = (o_gnt_idx == IDX_W'(N - 1)) ? '0 : o_gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end

endmodule

// File: rtl/alu_issue_arbiter.sv
// Shares one registered ALU between NUM_REQ issue slots and returns tagged results to writeback.
module alu_issue_arbiter
  import alu_issue_arbiter_pkg::*;
#(
  parameter  int unsigned NUM_REQ    = 4,
  parameter  int unsigned TAG_WIDTH  = ALU_TAG_WIDTH,
  parameter  int unsigned DATA_WIDTH = `DATA_WIDTH,
  localparam int unsigned SLOT_W     = $clog2(NUM_REQ)
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic [NUM_REQ-1:0]              i_req_valid,
  output logic [NUM_REQ-1:0]              o_req_ready,
  input  decoded_alu_op_t [NUM_REQ-1:0]   i_req_op,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   i_req_src1,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   i_req_src2,
  input  logic [NUM_REQ*TAG_WIDTH-1:0]    i_req_tag,
  input  logic                            i_flush,
  output logic                            o_alu_enabled,
  output decoded_alu_op_t                 o_alu_op,
  output logic [DATA_WIDTH-1:0]           o_alu_src1,
  output logic [DATA_WIDTH-1:0]           o_alu_src2,
  input  logic [DATA_WIDTH-1:0]           i_alu_dest,
  output logic                            o_res_valid,
  input  logic                            i_res_ready,
  output logic [DATA_WIDTH-1:0]           o_res_data,
  output logic [TAG_WIDTH-1:0]            o_res_tag,
  output logic [SLOT_W-1:0]               o_res_slot
);

  logic                 can_issue;
  logic [NUM_REQ-1:0]   gnt;
  logic [SLOT_W-1:0]    gnt_idx;
  logic [TAG_WIDTH-1:0] sel_tag;

  logic                 res_valid_q, res_valid_d;
  logic [TAG_WIDTH-1:0] res_tag_q,   res_tag_d;
  logic [SLOT_W-1:0]    res_slot_q,  res_slot_d;

  // A full result slot only frees up for a new op when writeback drains it this same cycle.
  assign can_issue = ~i_flush & (~res_valid_q | i_res_ready);

  rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_req     (i_req_valid),
    .i_en      (can_issue),
    .i_advance (can_issue),
    .o_gnt     (gnt),
    .o_gnt_idx (gnt_idx)
  );

  assign o_req_ready   = gnt;
  assign o_alu_enabled = |gnt;

  always_comb begin
    o_alu_op   = decoded_alu_op_t'('0);
    o_alu_src1 = '0;
    o_alu_src2 = '0;
    sel_tag    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (gnt[k]) begin
        o_alu_op   = i_req_op[k];
        o_alu_src1 = i_req_src1[k*DATA_WIDTH +: DATA_WIDTH];
        o_alu_src2 = i_req_src2[k*DATA_WIDTH +: DATA_WIDTH];
        sel_tag    = i_req_tag[k*TAG_WIDTH +: TAG_WIDTH];
      end
    end
  end

  always_comb begin
    res_valid_d = res_valid_q;
    res_tag_d   = res_tag_q;
    res_slot_d  = res_slot_q;
    if (i_flush) begin
      res_valid_d = 1'b0;
    end else if (o_alu_enabled) begin
      res_valid_d = 1'b1;
      res_tag_d   = sel_tag;
      res_slot_d  = gnt_idx;
    end else if (i_res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      res_valid_q <= 1'b0;
      res_tag_q   <= '0;
      res_slot_q  <= '0;
    end else begin
      res_valid_q <= res_valid_d;
      res_tag_q   <= res_tag_d;
      res_slot_q  <= res_slot_d;
    end
  end

  assign o_res_valid = res_valid_q;
  assign o_res_data  = i_alu_dest;
  assign o_res_tag   = res_tag_q;
  assign o_res_slot  = res_slot_q;

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Scoreboard bench for alu_issue_arbiter with a registered ALU model on the issue side.
module tb_alu_issue_arbiter;
  import alu_issue_arbiter_pkg::*;

  localparam int unsigned NR = 4;
  localparam int unsigned TW = ALU_TAG_WIDTH;
  localparam int unsigned DW = ALU_DATA_WIDTH;

  typedef struct {
    logic [DW-1:0] data;
    logic [TW-1:0] tag;
    logic [1:0]    slot;
  } exp_t;

  logic                       clk;
  logic                       rst_n;
  logic [NR-1:0]              i_req_valid;
  logic [NR-1:0]              o_req_ready;
  decoded_alu_op_t [NR-1:0]   i_req_op;
  logic [NR*DW-1:0]           i_req_src1;
  logic [NR*DW-1:0]           i_req_src2;
  logic [NR*TW-1:0]           i_req_tag;
  logic                       i_flush;
  logic                       o_alu_enabled;
  decoded_alu_op_t            o_alu_op;
  logic [DW-1:0]              o_alu_src1;
  logic [DW-1:0]              o_alu_src2;
  logic [DW-1:0]              alu_q;
  logic                       o_res_valid;
  logic                       i_res_ready;
  logic [DW-1:0]              o_res_data;
  logic [TW-1:0]              o_res_tag;
  logic [1:0]                 o_res_slot;

  alu_req_t req [NR];
  exp_t     exp_q[$];
  int       n_vec = 0;
  int       n_err = 0;

  alu_issue_arbiter #(.NUM_REQ(NR), .TAG_WIDTH(TW), .DATA_WIDTH(DW)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_op(i_req_op), .i_req_src1(i_req_src1), .i_req_src2(i_req_src2), .i_req_tag(i_req_tag),
    .i_flush(i_flush),
    .o_alu_enabled(o_alu_enabled), .o_alu_op(o_alu_op), .o_alu_src1(o_alu_src1), .o_alu_src2(o_alu_src2),
    .i_alu_dest(alu_q),
    .o_res_valid(o_res_valid), .i_res_ready(i_res_ready),
    .o_res_data(o_res_data), .o_res_tag(o_res_tag), .o_res_slot(o_res_slot)
  );

  function automatic logic [DW-1:0] alu_ref(decoded_alu_op_t op, logic [DW-1:0] a, logic [DW-1:0] b);
    logic [$clog2(DW)-1:0] sh;
    sh = b[$clog2(DW)-1:0];
    case (op)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_XOR: return a ^ b;
      ALU_SLL: return a << sh;
      ALU_SRL: return a >> sh;
      ALU_SLT: return DW'($signed(a) < $signed(b));
      default: return '0;
    endcase
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // The shared ALU: result registered, updated only on enabled cycles.
  always_ff @(posedge clk) begin
    if (o_alu_enabled) alu_q <= alu_ref(o_alu_op, o_alu_src1, o_alu_src2);
  end

  always_comb begin
    i_req_op   = '0;
    i_req_src1 = '0;
    i_req_src2 = '0;
    i_req_tag  = '0;
    for (int k = 0; k < NR; k++) begin
      i_req_op[k]             = req[k].op;
      i_req_src1[k*DW +: DW]  = req[k].src1;
      i_req_src2[k*DW +: DW]  = req[k].src2;
      i_req_tag[k*TW +: TW]   = req[k].tag;
    end
  end

  task automatic set_req(input int s, input decoded_alu_op_t op, input int a, input int b, input int t);
    req[s].op   = op;
    req[s].src1 = DW'(a);
    req[s].src2 = DW'(b);
    req[s].tag  = TW'(t);
  endtask

  task automatic apply_reset();
    rst_n       = 1'b0;
    i_req_valid = '0;
    i_flush     = 1'b0;
    i_res_ready = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // One clock of stimulus: compare issue side against the expected grant and
  // the result side against the scoreboard head, then update the scoreboard.
  task automatic drive_cycle(input logic [NR-1:0] v, input logic rdy, input logic fl,
                             input logic [NR-1:0] exp_gnt, input string name);
    int   g;
    logic exp_valid;
    exp_t e;
    i_req_valid = v;
    i_res_ready = rdy;
    i_flush     = fl;
    #1;
    g = 0;
    for (int k = 0; k < NR; k++) if (exp_gnt[k]) g = k;
    n_vec++;
    if (o_req_ready !== exp_gnt) begin
      n_err++;
      $display("FAIL %s grant: got %b want %b", name, o_req_ready, exp_gnt);
    end
    n_vec++;
    if (o_alu_enabled !== (|exp_gnt)) begin
      n_err++;
      $display("FAIL %s alu_enabled: got %b want %b", name, o_alu_enabled, |exp_gnt);
    end
    n_vec++;
    if (exp_gnt != '0) begin
      if ({o_alu_op, o_alu_src1, o_alu_src2} !== {req[g].op, req[g].src1, req[g].src2}) begin
        n_err++;
        $display("FAIL %s alu_drive: got op=%0d %0h %0h want op=%0d %0h %0h", name,
                 o_alu_op, o_alu_src1, o_alu_src2, req[g].op, req[g].src1, req[g].src2);
      end
    end else if ({o_alu_op, o_alu_src1, o_alu_src2} !== '0) begin
      n_err++;
      $display("FAIL %s alu_idle: got op=%0d %0h %0h want all zero", name, o_alu_op, o_alu_src1, o_alu_src2);
    end
    exp_valid = (exp_q.size() != 0);
    n_vec++;
    if (o_res_valid !== exp_valid) begin
      n_err++;
      $display("FAIL %s res_valid: got %b want %b", name, o_res_valid, exp_valid);
    end
    if (exp_valid) begin
      n_vec++;
      if (o_res_data !== exp_q[0].data || o_res_tag !== exp_q[0].tag || o_res_slot !== exp_q[0].slot) begin
        n_err++;
        $display("FAIL %s result: got data=%0h tag=%0d slot=%0d want data=%0h tag=%0d slot=%0d", name,
                 o_res_data, o_res_tag, o_res_slot, exp_q[0].data, exp_q[0].tag, exp_q[0].slot);
      end
    end
    if (fl) exp_q.delete();
    else if (exp_valid && rdy) void'(exp_q.pop_front());
    if (!fl && exp_gnt != '0) begin
      e.data = alu_ref(req[g].op, req[g].src1, req[g].src2);
      e.tag  = req[g].tag;
      e.slot = 2'(g);
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    i_req_valid = '0;
    i_flush = 1'b0;
    i_res_ready = 1'b1;
    #1;
    n_vec++;
    if (o_res_valid !== 1'b0 || o_res_tag !== '0 || o_res_slot !== '0) begin
      n_err++;
      $display("FAIL reset_result: got valid=%b tag=%0d slot=%0d want 0 0 0", o_res_valid, o_res_tag, o_res_slot);
    end
    n_vec++;
    if (o_req_ready !== '0 || o_alu_enabled !== 1'b0 || {o_alu_op, o_alu_src1, o_alu_src2} !== '0) begin
      n_err++;
      $display("FAIL reset_issue: got ready=%b en=%b op=%0d want all zero", o_req_ready, o_alu_enabled, o_alu_op);
    end
    apply_reset();
  endtask

  task automatic test_single();
    apply_reset();
    set_req(1, ALU_ADD, 5, 7, 3);
    drive_cycle(4'b0010, 1'b1, 1'b0, 4'b0010, "single_grant");
    n_vec++;
    if (o_res_data !== DW'(12)) begin
      n_err++;
      $display("FAIL single_data: got %0d want 12", o_res_data);
    end
    drive_cycle(4'b0000, 1'b1, 1'b0, 4'b0000, "single_drain");
  endtask

  task automatic test_round_robin();
    apply_reset();
    set_req(0, ALU_ADD, 100, 23, 10);
    set_req(1, ALU_SUB, 9, 4, 11);
    set_req(2, ALU_AND, 'hF0, 'h3C, 12);
    set_req(3, ALU_OR, 'h10, 'h01, 13);
    drive_cycle(4'b1111, 1'b1, 1'b0, 4'b0001, "rr_g0");
    drive_cycle(4'b1111, 1'b1, 1'b0, 4'b0010, "rr_g1");
    drive_cycle(4'b1111, 1'b1, 1'b0, 4'b0100, "rr_g2");
    drive_cycle(4'b1111, 1'b1, 1'b0, 4'b1000, "rr_g3");
    drive_cycle(4'b1111, 1'b1, 1'b0, 4'b0001, "rr_wrap");
    drive_cycle(4'b0000, 1'b1, 1'b0, 4'b0000, "rr_drain");
  endtask

  task automatic test_stall();
    apply_reset();
    set_req(0, ALU_SUB, 9, 4, 7);
    set_req(2, ALU_XOR, 'h55, 'hFF, 21);
    drive_cycle(4'b0001, 1'b1, 1'b0, 4'b0001, "stall_issue");
    for (int i = 0; i < 3; i++) drive_cycle(4'b0100, 1'b0, 1'b0, 4'b0000, "stall_hold");
    drive_cycle(4'b0100, 1'b1, 1'b0, 4'b0100, "stall_release");
    drive_cycle(4'b0000, 1'b1, 1'b0, 4'b0000, "stall_drain");
  endtask

  task automatic test_flush();
    apply_reset();
    set_req(0, ALU_SLL, 3, 4, 9);
    set_req(1, ALU_SLT, -2, 1, 4);
    drive_cycle(4'b0001, 1'b1, 1'b0, 4'b0001, "flush_issue");
    drive_cycle(4'b0010, 1'b1, 1'b1, 4'b0000, "flush_cycle");
    drive_cycle(4'b0010, 1'b1, 1'b0, 4'b0010, "flush_after");
    drive_cycle(4'b0000, 1'b1, 1'b0, 4'b0000, "flush_drain");
  endtask

  task automatic test_async_reset();
    apply_reset();
    set_req(0, ALU_ADD, 1, 2, 40);
    set_req(1, ALU_SRL, 'h80, 3, 41);
    set_req(3, ALU_SUB, 50, 8, 43);
    drive_cycle(4'b0010, 1'b1, 1'b0, 4'b0010, "areset_issue");
    drive_cycle(4'b1001, 1'b0, 1'b0, 4'b0000, "areset_full");
    #2;
    rst_n = 1'b0;
    i_req_valid = '0;
    #1;
    n_vec++;
    if (o_res_valid !== 1'b0 || o_res_tag !== '0) begin
      n_err++;
      $display("FAIL areset_drop: got valid=%b tag=%0d want 0 0", o_res_valid, o_res_tag);
    end
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    drive_cycle(4'b1001, 1'b1, 1'b0, 4'b0001, "areset_ptr0");
    drive_cycle(4'b1001, 1'b1, 1'b0, 4'b1000, "areset_next");
    drive_cycle(4'b0000, 1'b1, 1'b0, 4'b0000, "areset_drain");
  endtask

  task automatic test_back_to_back_slot3();
    apply_reset();
    set_req(0, ALU_ADD, 7, 7, 50);
    for (int i = 0; i < 5; i++) begin
      set_req(3, decoded_alu_op_t'(3'(i + 3)), 'h1234 + i, i + 1, 30 + i);
      drive_cycle(4'b1000, 1'b1, 1'b0, 4'b1000, "slot3_repeat");
    end
    drive_cycle(4'b1001, 1'b1, 1'b0, 4'b0001, "slot3_wrap");
    drive_cycle(4'b0000, 1'b1, 1'b0, 4'b0000, "slot3_drain");
  endtask

  initial begin
    for (int k = 0; k < NR; k++) set_req(k, ALU_ADD, 0, 0, 0);
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_flush();
    test_async_reset();
    test_back_to_back_slot3();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_issue_arbiter.md
Name: alu_issue_arbiter

Overview:
- Shares the single registered arithmetic unit between NUM_REQ issue slots.
- Each cycle it selects one valid request round-robin and drives the ALU enable, op and operands.
- It tracks the in-flight tag and returns the ALU result with that tag on a valid/ready result port toward writeback.
- It applies result backpressure and flush.

Parameters:
- NUM_REQ, 4, number of requesting issue slots (2..8).
- TAG_WIDTH, 6, width of the destination/ROB tag carried with each op.
- DATA_WIDTH, `DATA_WIDTH, operand/result width (from config).

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_req_valid  in  NUM_REQ  per-slot request valid.
- o_req_ready  out  NUM_REQ  one-hot grant; a request transfers when valid&ready.
- i_req_op  in  NUM_REQ x decoded_alu_op_t  per-slot ALU op.
- i_req_src1  in  NUM_REQ*DATA_WIDTH  per-slot operand 1, slot k at bits [k*DATA_WIDTH +: DATA_WIDTH].
- i_req_src2  in  NUM_REQ*DATA_WIDTH  per-slot operand 2, packed the same way.
- i_req_tag  in  NUM_REQ*TAG_WIDTH  per-slot tag, packed the same way.
- i_flush  in  1  kill the in-flight op and block grants this cycle.
- o_alu_enabled  out  1  ALU enable (combinational).
- o_alu_op  out  decoded_alu_op_t  op of the granted slot.
- o_alu_src1, o_alu_src2  out  DATA_WIDTH each  operands of the granted slot.
- i_alu_dest  in  DATA_WIDTH  registered ALU result.
- o_res_valid  out  1  result valid.
- i_res_ready  in  1  writeback accepts the result.
- o_res_data  out  DATA_WIDTH  equals i_alu_dest.
- o_res_tag  out  TAG_WIDTH  tag of the result.
- o_res_slot  out  $clog2(NUM_REQ)  originating slot index.

Behaviour:
- Reset (async assert, sync deassert in system):
  - o_res_valid=0, res_tag=0, res_slot=0, rr_ptr=0 (slot 0 highest priority).
  - Combinational outputs are 0 while no request is valid.
- Result slot state: EMPTY (res_valid=0) / FULL (res_valid=1). Single entry; no other FSM.
- can_issue = ~i_flush & (~res_valid | i_res_ready).
- Grant:
  - If can_issue, select the first valid slot searching from rr_ptr upward, modulo NUM_REQ.
  - o_req_ready is one-hot for that slot, else all 0.
  - Ready may depend combinationally on valid; requesters must not make valid depend on ready.
- ALU drive:
  - o_alu_enabled = |o_req_ready.
  - op/src1/src2 are muxed from the granted slot; they are 0 when not enabled.
- Pointer: on a grant to slot g, rr_ptr <= (g+1) mod NUM_REQ. With no grant, the pointer holds.
- Latency:
  - A request granted in cycle N has its result at o_res_valid in cycle N+1.
  - The ALU output updates only when enabled, so it holds while the result is stalled.
- Result register update per edge:
  - i_flush=1: res_valid <= 0, regardless of i_res_ready.
  - Else, on a grant: res_valid <= 1, res_tag/res_slot <= the granted slot's tag and index.
  - Else, if i_res_ready: res_valid <= 0.
  - Else: hold.
- Back-to-back: grant in a FULL cycle is allowed only with i_res_ready=1. Throughput is 1 op/cycle when writeback is always ready.
- Stall: while FULL and i_res_ready=0:
  - no grant, ALU not enabled, o_res_data/tag stable;
  - requests wait, and their valid and payload must stay stable.
- Flush:
  - Same-cycle flush and grant: flush wins and no grant is issued.
  - A result presented during the flush cycle is not considered transferred.
- Single requester: the same slot is granted every cycle it is valid.
- Reset mid-operation: the in-flight result is dropped and rr_ptr returns to 0.

Decomposition:
- Shared package (types.sv):
  - alu_req_t struct {decoded_alu_op_t op; src1; src2; tag};
  - ALU_TAG_WIDTH constant.
- Sub-module rr_arbiter:
  - parameter N;
  - inputs i_req[N], i_en, i_advance;
  - outputs o_gnt[N] one-hot, o_gnt_idx;
  - internal pointer with async reset.
- The top level holds the mux, the result register and flush logic.

Test Plan:
- Slot1 valid, op=ADD, src1=5, src2=7, tag=3, ready=1 → o_req_ready=4'b0010, o_alu_enabled=1 in cycle 0; cycle 1: o_res_valid=1, data=12, tag=3, slot=1.
- All 4 slots valid continuously, ready=1 → grants in order 0,1,2,3,0; results are one per cycle with matching tags.
- Slot0 granted (SUB 9-4, tag 7), i_res_ready=0 for 3 cycles with slot2 valid:
  - o_res_data=5 and tag=7 hold;
  - slot2 is not granted and o_alu_enabled=0;
  - when ready rises, slot2 is granted in the same cycle.
- i_flush in the cycle after the grant of tag 9 → o_res_valid=0 next cycle; a request valid in the flush cycle is not granted and is granted the following cycle.
- Assert i_rst_n=0 asynchronously mid-stall with FULL, rr_ptr=2 → o_res_valid=0 immediately; after release, slots 0 and 3 valid → slot 0 granted first.
- Slot3 only, 5 cycles valid, ready=1 → slot 3 is granted every cycle and the pointer wraps to 0 each time.
